// File: rtl/boot_handoff_ctrl_pkg.sv
// Shared types for the boot-to-user handoff controller.
// State encoding, fetch-source constants and a width helper.
package boot_pkg;

  typedef enum logic [2:0] {
    S_BIOS    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_HANDOFF = 3'd3,
    S_USER    = 3'd4
  } state_t;

  localparam logic FETCH_BIOS = 1'b0;
  localparam logic FETCH_IMEM = 1'b1;

  function automatic int cnt_width(int v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/boot_handoff_ctrl_if.sv
// Bus bundle between the handoff controller and core/disk/imem.
// master = controller side, slave = system side.
interface boot_handoff_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
);

  logic              start_copy;
  logic [ADDR_W-1:0] copy_base;
  logic [LEN_W-1:0]  copy_len;
  logic              disk_rd_en;
  logic [ADDR_W-1:0] disk_addr;
  logic [DATA_W-1:0] disk_rd_data;
  logic              disk_valid;
  logic              imem_wr_en;
  logic [ADDR_W-1:0] imem_wr_addr;
  logic [DATA_W-1:0] imem_wr_data;
  logic              program_end;
  logic              fetch_sel;
  logic              pc_clear;
  logic              cpu_stall;
  logic              copy_err;

  modport master (
    input  start_copy, copy_base, copy_len,
    input  disk_rd_data, disk_valid, program_end,
    output disk_rd_en, disk_addr,
    output imem_wr_en, imem_wr_addr, imem_wr_data,
    output fetch_sel, pc_clear, cpu_stall, copy_err
  );

  modport slave (
    output start_copy, copy_base, copy_len,
    output disk_rd_data, disk_valid, program_end,
    input  disk_rd_en, disk_addr,
    input  imem_wr_en, imem_wr_addr, imem_wr_data,
    input  fetch_sel, pc_clear, cpu_stall, copy_err
  );

endinterface

// File: rtl/boot_handoff_ctrl_timeout_cnt.sv
// Loadable down-counter; o_expire flags a zero count.
// Holds at zero once reached.
module boot_timeout_cnt #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/boot_handoff_ctrl.sv
// Boot handoff sequencer: BIOS load request -> disk copy into
// imem -> PC clear -> user fetch, and back to BIOS on program end.
module boot_handoff_ctrl
  import boot_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic rst,
  boot_handoff_ctrl_if.master bus
);

  localparam int TO_W = cnt_width(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);

  state_t            r_state, w_state;
  logic [ADDR_W-1:0] r_base, w_base;
  logic [LEN_W-1:0]  r_len, w_len;
  logic [LEN_W-1:0]  r_cnt, w_cnt;
  logic [LEN_W-1:0]  w_cnt_inc;
  logic              r_rd_en, w_rd_en;
  logic [ADDR_W-1:0] r_disk_addr, w_disk_addr;
  logic              r_wr_en, w_wr_en;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr;
  logic [DATA_W-1:0] r_wr_data, w_wr_data;
  logic              r_fetch, w_fetch;
  logic              r_pc_clr, w_pc_clr;
  logic              r_stall, w_stall;
  logic              r_err, w_err;
  logic              w_expire;
  logic              w_timeout;

  boot_timeout_cnt #(.W(TO_W)) u_to (
    .clock      (clock),
    .rst        (rst),
    .i_load     (r_state == S_REQ),
    .i_load_val (TO_LOAD),
    .i_dec      ((r_state == S_WAIT) && !bus.disk_valid),
    .o_expire   (w_expire)
  );

  assign w_timeout = (TIMEOUT != 0) && w_expire;
  assign w_cnt_inc = r_cnt + LEN_W'(1);

  always_comb begin
    w_state     = r_state;
    w_base      = r_base;
    w_len       = r_len;
    w_cnt       = r_cnt;
    w_rd_en     = 1'b0;
    w_disk_addr = r_disk_addr;
    w_wr_en     = 1'b0;
    w_wr_addr   = r_wr_addr;
    w_wr_data   = r_wr_data;
    w_pc_clr    = 1'b0;
    w_err       = r_err;
    unique case (r_state)
      S_BIOS: begin
        if (bus.start_copy) begin
          w_err = 1'b0;
          if (bus.copy_len != '0) begin
            w_base      = bus.copy_base;
            w_len       = bus.copy_len;
            w_cnt       = '0;
            w_rd_en     = 1'b1;
            w_disk_addr = bus.copy_base;
            w_state     = S_REQ;
          end else begin
            w_state = S_HANDOFF;
          end
        end
      end
      S_REQ: w_state = S_WAIT;
      S_WAIT: begin
        if (bus.disk_valid) begin
          w_wr_en   = 1'b1;
          w_wr_addr = ADDR_W'(r_cnt);
          w_wr_data = bus.disk_rd_data;
          w_cnt     = w_cnt_inc;
          if (w_cnt_inc == r_len) begin
            w_state = S_HANDOFF;
          end else begin
            w_rd_en     = 1'b1;
            w_disk_addr = r_base + ADDR_W'(w_cnt_inc);
            w_state     = S_REQ;
          end
        end else if (w_timeout) begin
          w_err   = 1'b1;
          w_state = S_BIOS;
        end
      end
      S_HANDOFF: w_state = S_USER;
      S_USER: begin
        if (bus.program_end) begin
          w_pc_clr = 1'b1;
          w_state  = S_BIOS;
        end
      end
      default: w_state = S_BIOS;
    endcase
    // HANDOFF is only ever entered, never held, so this is a pulse
    if (w_state == S_HANDOFF) w_pc_clr = 1'b1;
    w_stall = (w_state == S_REQ) || (w_state == S_WAIT) ||
              (w_state == S_HANDOFF);
    // fetch source trails the pc_clear pulse by one cycle both ways
    w_fetch = ((r_state == S_HANDOFF) || (r_state == S_USER)) ?
              FETCH_IMEM : FETCH_BIOS;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state     <= S_BIOS;
      r_base      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_rd_en     <= 1'b0;
      r_disk_addr <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_fetch     <= FETCH_BIOS;
      r_pc_clr    <= 1'b0;
      r_stall     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_base      <= w_base;
      r_len       <= w_len;
      r_cnt       <= w_cnt;
      r_rd_en     <= w_rd_en;
      r_disk_addr <= w_disk_addr;
      r_wr_en     <= w_wr_en;
      r_wr_addr   <= w_wr_addr;
      r_wr_data   <= w_wr_data;
      r_fetch     <= w_fetch;
      r_pc_clr    <= w_pc_clr;
      r_stall     <= w_stall;
      r_err       <= w_err;
    end
  end

  assign bus.disk_rd_en   = r_rd_en;
  assign bus.disk_addr    = r_disk_addr;
  assign bus.imem_wr_en   = r_wr_en;
  assign bus.imem_wr_addr = r_wr_addr;
  assign bus.imem_wr_data = r_wr_data;
  assign bus.fetch_sel    = r_fetch;
  assign bus.pc_clear     = r_pc_clr;
  assign bus.cpu_stall    = r_stall;
  assign bus.copy_err     = r_err;

endmodule

// File: tb/tb_boot_handoff_ctrl.sv
// Scoreboard bench for boot_handoff_ctrl: stimulus pushes expected
// disk reads, imem writes and PC-clear events; a monitor pops them.
module tb_boot_handoff_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int TO = 8;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic cur;
    logic nxt;
  } pc_t;

  logic clock = 1'b0;
  logic rst   = 1'b1;

  always #5 clock = ~clock;

  boot_handoff_ctrl_if #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)
  ) bus ();

  boot_handoff_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .TIMEOUT(TO)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  logic [31:0] exp_rd[$];
  wr_t         exp_wr[$];
  pc_t         exp_pc[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_rd_cyc = 0;
  int rd_seen = 0;
  int resp_limit = 32'h3fff_ffff;
  bit exp_err = 0;
  bit directed = 0;
  bit noise_en = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // disk contents, independent of the controller
  function automatic logic [31:0] dmem(logic [31:0] a);
    if (directed) return 32'hA0 + (a - 32'h100);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // disk responder: valid arrives 1..5 cycles after each read strobe
  initial begin
    int cd;
    logic [31:0] ra;
    cd = 0;
    ra = '0;
    bus.disk_valid   = 1'b0;
    bus.disk_rd_data = '0;
    forever begin
      @(negedge clock);
      bus.disk_valid = 1'b0;
      if (!rst) begin
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            bus.disk_valid   = 1'b1;
            bus.disk_rd_data = dmem(ra);
          end
        end else if (noise_en && !bus.cpu_stall &&
                     $urandom_range(0, 3) == 0) begin
          bus.disk_valid   = 1'b1;
          bus.disk_rd_data = $urandom;
        end
        if (bus.disk_rd_en) begin
          ra = bus.disk_addr;
          rd_seen++;
          if (rd_seen <= resp_limit) cd = $urandom_range(1, 5);
        end
      end
    end
  end

  // monitor
  initial begin
    bit pc_pend;
    bit pend_val;
    bit prev_err;
    logic [31:0] ea;
    wr_t w;
    pc_t p;
    pc_pend = 0;
    pend_val = 0;
    prev_err = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (!rst) begin
        pc_pend = 0;
        prev_err = 0;
      end else begin
        if (pc_pend) begin
          chk("fetch_after_pc", bus.fetch_sel, pend_val);
          pc_pend = 0;
        end
        if (bus.disk_rd_en) begin
          last_rd_cyc = cyc;
          chk("stall_on_rd", bus.cpu_stall, 1);
          if (exp_rd.size() == 0) begin
            chk("unexp_rd", bus.disk_rd_en, 0);
          end else begin
            ea = exp_rd.pop_front();
            chk("disk_addr", bus.disk_addr, ea);
          end
        end
        if (bus.imem_wr_en) begin
          chk("stall_on_wr", bus.cpu_stall, 1);
          if (exp_wr.size() == 0) begin
            chk("unexp_wr", bus.imem_wr_en, 0);
          end else begin
            w = exp_wr.pop_front();
            chk("imem_addr", bus.imem_wr_addr, w.a);
            chk("imem_data", bus.imem_wr_data, w.d);
          end
        end
        if (bus.pc_clear) begin
          if (exp_pc.size() == 0) begin
            chk("unexp_pc", bus.pc_clear, 0);
          end else begin
            p = exp_pc.pop_front();
            chk("fetch_at_pc", bus.fetch_sel, p.cur);
            chk("wr_done_at_pc", exp_wr.size(), 0);
            pc_pend = 1;
            pend_val = p.nxt;
          end
        end
        if (bus.copy_err && !prev_err) begin
          if (exp_err) begin
            chk("timeout_lat", cyc - last_rd_cyc, TO + 1);
            exp_err = 0;
          end else begin
            chk("unexp_err", bus.copy_err, 0);
          end
        end
        prev_err = bus.copy_err;
      end
    end
  end

  // which: 0 = idle in BIOS, 1 = running user, 2 = copy_err set
  task automatic wait_cond(string nm, int which, int bound);
    int n;
    bit ok;
    n = 0;
    forever begin
      case (which)
        0: ok = !bus.fetch_sel && !bus.cpu_stall && !bus.pc_clear;
        1: ok = bus.fetch_sel && !bus.cpu_stall;
        default: ok = bus.copy_err;
      endcase
      if (ok) return;
      if (n == bound) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s: condition not reached in %0d cycles",
                 nm, bound);
        return;
      end
      n++;
      @(negedge clock);
    end
  endtask

  // mode 0: full copy, 1: disk silent (timeout), 2: no wait
  task automatic issue_copy(logic [31:0] base, int len, int mode);
    wr_t w;
    pc_t p;
    wait_cond("wait_bios", 0, 100);
    if (mode == 1) begin
      exp_rd.push_back(base);
      exp_err = 1;
    end else begin
      for (int i = 0; i < len; i++) begin
        exp_rd.push_back(base + 32'(i));
        w.a = 32'(i);
        w.d = dmem(base + 32'(i));
        exp_wr.push_back(w);
      end
      p.cur = 1'b0;
      p.nxt = 1'b1;
      exp_pc.push_back(p);
    end
    @(negedge clock);
    bus.start_copy = 1'b1;
    bus.copy_base  = base;
    bus.copy_len   = LW'(len);
    @(negedge clock);
    bus.start_copy = 1'b0;
    bus.copy_base  = $urandom;
    bus.copy_len   = LW'($urandom);
    chk("err_cleared", bus.copy_err, 0);
    if (len == 0) begin
      chk("len0_pc", bus.pc_clear, 1);
      chk("len0_fetch0", bus.fetch_sel, 0);
      @(negedge clock);
      chk("len0_fetch1", bus.fetch_sel, 1);
      chk("len0_pc_off", bus.pc_clear, 0);
    end
    if (mode == 0) wait_cond("wait_user", 1, len * 10 + 20);
  endtask

  task automatic end_prog(bit with_start);
    pc_t p;
    wait_cond("wait_user_end", 1, 50);
    p.cur = 1'b1;
    p.nxt = 1'b0;
    exp_pc.push_back(p);
    @(negedge clock);
    bus.program_end = 1'b1;
    bus.start_copy  = with_start;
    bus.copy_len    = LW'(5);
    @(negedge clock);
    bus.program_end = 1'b0;
    bus.start_copy  = 1'b0;
    chk("end_pc", bus.pc_clear, 1);
    chk("end_fetch_hold", bus.fetch_sel, 1);
    @(negedge clock);
    chk("end_fetch0", bus.fetch_sel, 0);
    chk("end_pc_off", bus.pc_clear, 0);
    wait_cond("wait_bios_end", 0, 20);
  endtask

  initial begin
    int base_rd;
    int n;
    bus.start_copy  = 1'b0;
    bus.copy_base   = '0;
    bus.copy_len    = '0;
    bus.program_end = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    chk("rst_fetch", bus.fetch_sel, 0);
    chk("rst_stall", bus.cpu_stall, 0);
    chk("rst_rd", bus.disk_rd_en, 0);
    chk("rst_wr", bus.imem_wr_en, 0);
    chk("rst_pc", bus.pc_clear, 0);
    chk("rst_err", bus.copy_err, 0);

    directed = 1;
    issue_copy(32'h100, 3, 0);
    directed = 0;
    end_prog(0);

    issue_copy(32'h200, 0, 0);
    @(negedge clock);
    bus.start_copy = 1'b1;
    bus.copy_len   = LW'(4);
    repeat (3) @(negedge clock);
    bus.start_copy = 1'b0;
    chk("user_ign_fetch", bus.fetch_sel, 1);
    chk("user_ign_stall", bus.cpu_stall, 0);
    end_prog(1);

    noise_en = 1;
    for (int i = 0; i < 6; i++) begin
      issue_copy((i == 0) ? 32'hFFFF_FFFE : $urandom,
                 $urandom_range(1, 8), 0);
      end_prog(i[0]);
    end

    resp_limit = rd_seen;
    issue_copy($urandom, 3, 1);
    wait_cond("wait_err", 2, 60);
    chk("to_fetch", bus.fetch_sel, 0);
    chk("to_stall", bus.cpu_stall, 0);
    chk("to_err", bus.copy_err, 1);
    resp_limit = 32'h3fff_ffff;
    repeat (4) @(negedge clock);
    chk("err_sticky", bus.copy_err, 1);

    issue_copy(32'h40, 2, 0);
    end_prog(0);

    noise_en = 0;
    base_rd = rd_seen;
    resp_limit = rd_seen + 1;
    issue_copy(32'h300, 4, 2);
    n = 0;
    while (rd_seen < base_rd + 2 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("mid_rd_count", rd_seen, base_rd + 2);
    repeat (2) @(negedge clock);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_fetch", bus.fetch_sel, 0);
    chk("mid_rst_stall", bus.cpu_stall, 0);
    chk("mid_rst_wr", bus.imem_wr_en, 0);
    chk("mid_rst_rd", bus.disk_rd_en, 0);
    chk("mid_rst_pc", bus.pc_clear, 0);
    exp_rd.delete();
    exp_wr.delete();
    exp_pc.delete();
    resp_limit = 32'h3fff_ffff;
    repeat (3) @(negedge clock);
    rst = 1'b1;
    repeat (20) @(negedge clock);
    chk("post_rst_fetch", bus.fetch_sel, 0);
    chk("post_rst_stall", bus.cpu_stall, 0);

    chk("rd_q_empty", exp_rd.size(), 0);
    chk("wr_q_empty", exp_wr.size(), 0);
    chk("pc_q_empty", exp_pc.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
